// File: rtl/motor_cmd_spi_rx_pkg.sv
// Shared types for the motor command path: per-motor command word, frame size
// and receiver FSM states. motor_controller consumes motor_cmd_t as well.
package motor_cmd_pkg;

  typedef struct packed {
    logic       sign;
    logic [6:0] period;
  } motor_cmd_t;

  localparam int unsigned FRAME_BITS  = 16;
  localparam int unsigned BIT_CNT_SAT = FRAME_BITS + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  function automatic motor_cmd_t stop_cmd(input logic [6:0] stop_period);
    motor_cmd_t c;
    c.sign   = 1'b0;
    c.period = stop_period;
    return c;
  endfunction

endpackage

// File: rtl/motor_cmd_spi_rx_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a third flop that
// yields single-cycle rise/fall strobes in the clk domain.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/motor_cmd_spi_rx.sv
// SPI-slave receiver for 16-bit motor command frames with double-buffered
// outputs, malformed-frame accounting and a stop-forcing watchdog.
module motor_cmd_spi_rx
  import motor_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 600000,
  parameter logic [6:0]  STOP_PERIOD    = 7'd0,
  parameter int unsigned ERR_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             sdi,
  input  logic             ce,
  output logic             motor1_sign,
  output logic [6:0]       motor1_period,
  output logic             motor2_sign,
  output logic [6:0]       motor2_period,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_count,
  output logic             timeout
);

  localparam int unsigned      WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]       CNT_OK  = 5'(FRAME_BITS);
  localparam logic [4:0]       CNT_SAT = 5'(BIT_CNT_SAT);

  logic w_sck_sync;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_ce_sync;
  logic w_ce_rise;
  logic w_ce_fall;
  logic w_unused;

  logic r_sdi_meta;
  logic r_sdi_sync;

  state_t r_state;
  state_t w_next;

  logic [FRAME_BITS-1:0] r_shift;
  logic [4:0]            r_bit_cnt;
  logic [WD_W-1:0]       r_wd;
  logic                  w_good;
  logic                  w_bad;

  motor_cmd_t       r_m1;
  motor_cmd_t       r_m2;
  logic             r_frame_valid;
  logic             r_frame_err;
  logic [ERR_W-1:0] r_err_count;
  logic             r_timeout;

  sync_edge u_sck_sync (
    .clk    (clk),
    .reset  (reset),
    .i_async(sck),
    .o_sync (w_sck_sync),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  sync_edge u_ce_sync (
    .clk    (clk),
    .reset  (reset),
    .i_async(ce),
    .o_sync (w_ce_sync),
    .o_rise (w_ce_rise),
    .o_fall (w_ce_fall)
  );

  assign w_unused = ^{w_sck_sync, w_sck_fall, w_ce_sync};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sdi_meta <= 1'b0;
      r_sdi_sync <= 1'b0;
    end else begin
      r_sdi_meta <= sdi;
      r_sdi_sync <= r_sdi_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_ce_rise) w_next = SHIFT;
      SHIFT:   if (w_ce_fall) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ce_fall takes priority over a coincident sck_rise, so that edge is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (r_state == IDLE && w_ce_rise) begin
        r_bit_cnt <= '0;
      end else if (r_state == SHIFT && !w_ce_fall && w_sck_rise) begin
        r_shift <= {r_shift[FRAME_BITS-2:0], r_sdi_sync};
        if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + 5'd1;
      end
    end
  end

  assign w_good = (r_state == COMMIT) && (r_bit_cnt == CNT_OK);
  assign w_bad  = (r_state == COMMIT) && (r_bit_cnt != CNT_OK);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_frame_valid <= w_good;
      r_frame_err   <= w_bad;
      if (w_bad && r_err_count != '1) r_err_count <= r_err_count + 1'b1;
    end
  end

  // A good commit overrides the watchdog even on the cycle it would expire.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m1      <= stop_cmd(STOP_PERIOD);
      r_m2      <= stop_cmd(STOP_PERIOD);
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else if (w_good) begin
      r_m1      <= r_shift[15:8];
      r_m2      <= r_shift[7:0];
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_wd != WD_MAX) r_wd <= r_wd + 1'b1;
      if (r_wd >= WD_LAST) begin
        r_m1      <= stop_cmd(STOP_PERIOD);
        r_m2      <= stop_cmd(STOP_PERIOD);
        r_timeout <= 1'b1;
      end
    end
  end

  assign motor1_sign   = r_m1.sign;
  assign motor1_period = r_m1.period;
  assign motor2_sign   = r_m2.sign;
  assign motor2_period = r_m2.period;
  assign frame_valid   = r_frame_valid;
  assign frame_err     = r_frame_err;
  assign err_count     = r_err_count;
  assign timeout       = r_timeout;

endmodule

// File: doc/motor_cmd_spi_rx.md
Name: motor_cmd_spi_rx

Overview:
- SPI-slave command receiver that sits directly upstream of motor_controller, inside top.
- Receives 16-bit motor command frames from the MCU (balance/PID loop). Drives motor1_sign/motor1_period/motor2_sign/motor2_period, replacing the constant tie-offs.
- Frames are double-buffered: outputs change only on a complete, well-formed frame.
- A watchdog forces both motors to stop if the MCU goes silent.

Parameters:
- TIMEOUT_CYCLES, 600000, clk cycles without a good frame before outputs are forced to stop (100 ms at 6 MHz).
- STOP_PERIOD, 7'd0, period value driven on reset and timeout. motor_controller treats period 0 as stopped.
- ERR_W, 8, width of the saturating frame-error counter.

Ports:
- clk  input  1  system clock (int_osc domain). Must be ≥ 4x SCK frequency.
- reset  input  1  synchronous, active-high reset.
- sck  input  1  SPI clock from MCU, asynchronous to clk, idle low.
- sdi  input  1  SPI data from MCU, MSB first, sampled on rising sck.
- ce  input  1  frame enable from MCU, active-high, asynchronous.
- motor1_sign  output  1  motor 1 direction.
- motor1_period  output  7  motor 1 step period.
- motor2_sign  output  1  motor 2 direction.
- motor2_period  output  7  motor 2 step period.
- frame_valid  output  1  one-cycle pulse when a new frame is committed.
- frame_err  output  1  one-cycle pulse when a malformed frame is discarded.
- err_count  output  ERR_W  saturating count of malformed frames.
- timeout  output  1  high while the watchdog has forced stop.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high.
- Reset values:
  - motorN_sign = 0, motorN_period = STOP_PERIOD.
  - frame_valid = 0, frame_err = 0, err_count = 0, timeout = 0.
  - Shift register, bit counter and watchdog counter = 0.
  - Synchronizer flops = 0.
- Input synchronization: sck, sdi and ce each pass through a 2-flop synchronizer. sck and ce get one more flop for edge detection.
  - sck_rise = synced sck & ~prev.
  - ce_rise and ce_fall are defined the same way.
- Frame format (16 bits, MSB first):
  - bit15 = motor1_sign, bits14:8 = motor1_period.
  - bit7 = motor2_sign, bits6:0 = motor2_period.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: wait for ce_rise. On ce_rise, clear bit counter and go to SHIFT.
  - SHIFT: on each sck_rise, shift synced sdi into shift[0] and increment bit_cnt. bit_cnt is 5 bits and saturates at 17; any count > 16 marks overrun. On ce_fall, go to COMMIT.
  - COMMIT (one cycle), then IDLE:
    - If bit_cnt == 16: load outputs from shift, pulse frame_valid, clear watchdog, deassert timeout.
    - Otherwise: leave outputs unchanged, pulse frame_err, increment err_count (saturating at all-ones).
- Latency: outputs and frame_valid update on the clk edge after the cycle in which ce_fall is detected. That is 4 clk cycles after ce falls at the pin.
- Edge cases:
  - sck edges while ce is low (IDLE) are ignored.
  - ce_rise while in SHIFT cannot occur, since ce must fall first. ce_fall in IDLE is ignored.
  - sck_rise and ce_fall in the same cycle: ce_fall wins, and that sck edge is not counted.
- Watchdog:
  - The counter increments every cycle unless a commit occurs, and saturates at TIMEOUT_CYCLES.
  - When the counter reaches TIMEOUT_CYCLES: force motorN_period = STOP_PERIOD and motorN_sign = 0, and set timeout = 1.
  - timeout holds until the next good commit.
  - Good commit and timeout threshold in the same cycle: the commit wins. Outputs load the new frame, the counter clears and timeout stays 0.
  - Bad frames do not feed the watchdog.
- Reset mid-frame: the partial frame is discarded. The FSM goes to IDLE and requires a fresh ce_rise.
- A period value of 0 inside a valid frame is accepted as-is.

Decomposition:
- Package motor_cmd_pkg holds:
  - motor_cmd_t packed struct {sign: 1 bit, period: 7 bits}.
  - FRAME_BITS = 16.
  - State enum {IDLE, SHIFT, COMMIT}.
  - motor_controller also uses motor_cmd_t.
- Sub-module sync_edge (2-flop synchronizer plus rise/fall detect, reset to 0), instantiated for sck and ce. sdi uses its synchronized output only.

Test Plan:
- Reset, then frame 16'h9E32 (16 bits, sck = clk/8) -> frame_valid pulses once. motor1_sign = 1, motor1_period = 7'd30, motor2_sign = 0, motor2_period = 7'd50. err_count = 0.
- Frame of 15 bits, then 17 bits -> two frame_err pulses, err_count = 2, outputs keep the previous values (30/50), no frame_valid.
- TIMEOUT_CYCLES = 1000: one good frame, then idle 1000 cycles -> timeout = 1, both periods 0, signs 0. Next good frame 16'h0164 -> timeout = 0, motor1_period = 1, motor2_sign = 0, motor2_period = 100.
- Good frame whose commit cycle coincides with watchdog reaching 1000 -> new values loaded, timeout stays 0, counter = 0.
- Assert reset after 9 bits of a frame, release, then send 16'h8A05 -> outputs = 1/10/0/5 and no frame_err from the aborted frame.
- 20 sck pulses with ce low, then 300 short frames with ERR_W = 8 -> no state change from the sck pulses; err_count saturates at 255.
